// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings and the round-robin pick rule for the two-requester arbiter.
package mux2_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // On a tie the requester that did not win last time gets the grant.
  function automatic logic [1:0] arbitrate(input logic a_req, input logic b_req,
                                           input logic last);
    if (a_req && b_req) return (last == SRC_A) ? ST_GNT_B : ST_GNT_A;
    if (a_req)          return ST_GNT_A;
    if (b_req)          return ST_GNT_B;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// WIDTH-bit combinational 2:1 mux: f = s ? b : a.
module mux2_1_vec #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] f,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  assign f = s ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter feeding a one-deep valid/ready output register through a 2:1 mux.
// Optional feature: define ARB_LOCK_EN to add a_lock/b_lock grant-locking inputs.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ack,
`ifdef ARB_LOCK_EN
  input  logic             a_lock,
  input  logic             b_lock,
`endif
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);
  import mux2_rr_arbiter_pkg::*;

  logic [1:0]       state;
  logic             last;
  logic             slot_free;
  logic             a_hold;
  logic             b_hold;
  logic [WIDTH-1:0] mux_out;

`ifdef ARB_LOCK_EN
  assign a_hold = a_lock;
  assign b_hold = b_lock;
`else
  assign a_hold = 1'b0;
  assign b_hold = 1'b0;
`endif

  // A word leaving this cycle frees the register for a same-cycle refill.
  assign slot_free = ~out_valid | out_ready;
  assign sel       = (state == ST_GNT_B);
  assign a_ack     = (state == ST_GNT_A) & a_req & slot_free;
  assign b_ack     = (state == ST_GNT_B) & b_req & slot_free;

  mux2_1_vec #(.WIDTH(WIDTH)) u_mux (
    .f (mux_out),
    .s (sel),
    .a (a_data),
    .b (b_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last      <= SRC_B;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_A;
    end else begin
      if (a_ack || b_ack) begin
        out_valid <= 1'b1;
        out_data  <= mux_out;
        out_src   <= b_ack ? SRC_B : SRC_A;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A granted requester is never preempted; it keeps the grant until acked or withdrawn.
      case (state)
        ST_IDLE: state <= arbitrate(a_req, b_req, last);
        ST_GNT_A: begin
          if (!a_req) begin
            state <= ST_IDLE;
          end else if (a_ack && !a_hold) begin
            last  <= SRC_A;
            state <= arbitrate(a_req, b_req, SRC_A);
          end
        end
        ST_GNT_B: begin
          if (!b_req) begin
            state <= ST_IDLE;
          end else if (b_ack && !b_hold) begin
            last  <= SRC_B;
            state <= arbitrate(a_req, b_req, SRC_B);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus randomized run vs a reference model.
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_req = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ack;
  logic             b_req = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ack;
  logic             a_lock = 1'b0;
  logic             b_lock = 1'b0;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready = 1'b0;

  int check_count = 0;
  int err_count   = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ARB_LOCK_EN
    .a_lock    (a_lock),
    .b_lock    (b_lock),
`endif
    .a_req     (a_req),
    .a_data    (a_data),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_data    (b_data),
    .b_ack     (b_ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // Observation vector: {a_ack, b_ack, sel, out_valid, out_src, out_data}
  function automatic logic [WIDTH+4:0] obs();
    return {a_ack, b_ack, sel, out_valid, out_src, out_data};
  endfunction

  task automatic idle_inputs();
    a_req = 1'b0; b_req = 1'b0; a_data = '0; b_data = '0;
    a_lock = 1'b0; b_lock = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH+4:0] exp;
    #1;
    check_count++;
    if (obs() !== '0) begin
      err_count++;
      $display("FAIL reset_initial: got %h expected %h", obs(), 13'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_data = 8'h5A; b_data = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_count++;
    if (obs() !== '0) begin
      err_count++;
      $display("FAIL reset_async_mid_transfer: got %h expected %h", obs(), 13'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    check_count++;
    if (obs() !== exp) begin
      err_count++;
      $display("FAIL reset_release_a_first: got %h expected %h", obs(), exp);
    end
  endtask

  task automatic test_single_a();
    logic [WIDTH+4:0] exp;
    do_reset();
    @(negedge clk);
    a_req = 1'b1; a_data = 8'h3C; out_ready = 1'b1;
    #1;
    check_count++;
    if (obs() !== '0) begin
      err_count++;
      $display("FAIL single_a_cycle0: got %h expected %h", obs(), 13'h0);
    end
    @(negedge clk);
    #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    check_count++;
    if (obs() !== exp) begin
      err_count++;
      $display("FAIL single_a_ack: got %h expected %h", obs(), exp);
    end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
    check_count++;
    if (obs() !== exp) begin
      err_count++;
      $display("FAIL single_a_out: got %h expected %h", obs(), exp);
    end
    @(negedge clk);
    #1;
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    check_count++;
    if (obs() !== exp) begin
      err_count++;
      $display("FAIL single_a_drained: got %h expected %h", obs(), exp);
    end
  endtask

  task automatic test_contention();
    logic [WIDTH+4:0] exp;
    logic [WIDTH-1:0] prev_data;
    logic             prev_src;
    do_reset();
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; a_data = 8'h10; b_data = 8'h20; out_ready = 1'b1;
    prev_data = '0;
    prev_src  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_data = 8'h10 + 8'(k);
      b_data = 8'h20 + 8'(k);
      #1;
      exp = {(k % 2 == 0), (k % 2 == 1), (k % 2 == 1), (k > 0), prev_src, prev_data};
      check_count++;
      if (obs() !== exp) begin
        err_count++;
        $display("FAIL contention_k%0d: got %h expected %h", k, obs(), exp);
      end
      prev_data = (k % 2 == 0) ? a_data : b_data;
      prev_src  = (k % 2 == 1);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH+4:0] exp [7];
    exp[0] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    exp[1] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    exp[2] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
    exp[3] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
    exp[4] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
    exp[5] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22};
    exp[6] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      case (n)
        0: begin a_req = 1'b1; a_data = 8'h11; end
        2: begin a_data = 8'h22; b_req = 1'b1; b_data = 8'h33; end
        4: out_ready = 1'b1;
        5: a_req = 1'b0;
        6: b_req = 1'b0;
        default: ;
      endcase
      #1;
      check_count++;
      if (obs() !== exp[n]) begin
        err_count++;
        $display("FAIL backpressure_n%0d: got %h expected %h", n, obs(), exp[n]);
      end
    end
  endtask

  task automatic test_withdraw();
    logic [WIDTH+4:0] exp [7];
    exp[0] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    exp[1] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    exp[2] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77};
    exp[3] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77};
    exp[4] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77};
    exp[5] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77};
    exp[6] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      case (n)
        0: begin b_req = 1'b1; b_data = 8'h77; end
        2: b_data = 8'h99;
        3: b_req = 1'b0;
        5: out_ready = 1'b1;
        default: ;
      endcase
      #1;
      check_count++;
      if (obs() !== exp[n]) begin
        err_count++;
        $display("FAIL withdraw_n%0d: got %h expected %h", n, obs(), exp[n]);
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [WIDTH+4:0] exp;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 0) begin
        a_req = 1'b1; b_req = 1'b1; a_data = 8'hAA; b_data = 8'hBB;
        a_lock = 1'b1; out_ready = 1'b1;
      end
      if (n == 4) a_lock = 1'b0;
      #1;
      if (n == 0)      exp = '0;
      else if (n == 1) exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      else if (n < 5)  exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA};
      else             exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA};
      check_count++;
      if (obs() !== exp) begin
        err_count++;
        $display("FAIL lock_n%0d: got %h expected %h", n, obs(), exp);
      end
    end
  endtask
`endif

  // Reference model: who holds the grant (0 none, 1 A, 2 B), who won last, and the output slot.
  function automatic int pick(bit a, bit b, bit last_b);
    if (a && b) return last_b ? 1 : 2;
    if (a) return 1;
    if (b) return 2;
    return 0;
  endfunction

  task automatic test_random();
    int               owner;
    bit               last_b;
    bit               m_valid;
    bit               m_src;
    logic [WIDTH-1:0] m_data;
    bit               free, ea, eb, lock_a, lock_b;
    logic [WIDTH+4:0] exp;
    do_reset();
    owner = 0; last_b = 1'b1; m_valid = 1'b0; m_src = 1'b0; m_data = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      a_req     = ($urandom_range(0, 3) != 0);
      b_req     = ($urandom_range(0, 3) != 0);
      a_data    = WIDTH'($urandom);
      b_data    = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      a_lock    = $urandom_range(0, 1) == 1;
      b_lock    = $urandom_range(0, 1) == 1;
`ifdef ARB_LOCK_EN
      lock_a = a_lock; lock_b = b_lock;
`else
      lock_a = 1'b0;   lock_b = 1'b0;
`endif
      #1;
      free = !m_valid || out_ready;
      ea   = (owner == 1) && a_req && free;
      eb   = (owner == 2) && b_req && free;
      exp  = {ea, eb, (owner == 2), m_valid, m_src, m_data};
      check_count++;
      if (obs() !== exp) begin
        err_count++;
        $display("FAIL random_n%0d: got %h expected %h", n, obs(), exp);
      end
      if (ea)             begin m_valid = 1'b1; m_data = a_data; m_src = 1'b0; end
      else if (eb)        begin m_valid = 1'b1; m_data = b_data; m_src = 1'b1; end
      else if (out_ready) m_valid = 1'b0;
      if (owner == 0) begin
        owner = pick(a_req, b_req, last_b);
      end else if (owner == 1) begin
        if (!a_req) owner = 0;
        else if (ea && !lock_a) begin last_b = 1'b0; owner = pick(a_req, b_req, 1'b0); end
      end else begin
        if (!b_req) owner = 0;
        else if (eb && !lock_b) begin last_b = 1'b1; owner = pick(a_req, b_req, 1'b1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_backpressure();
    test_withdraw();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
    $finish;
  end

endmodule
